// File: rtl/rs232_pkg.sv
// rs232_pkg: definitions shared by the RS232 receive and transmit paths.
//   rx_state_t     - receiver FSM state encoding
//   DATA_BITS      - data bits per frame (8N1)
//   STOP_LEVEL     - line level of a valid stop bit
//   IDLE_LEVEL     - line level of an idle line
//   calc_bps_div   - clock cycles per bit, CLK_FREQ / BAUD (integer division)
//   calc_bps_half  - half a bit period, used to land samples at mid-bit
package rs232_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // The divider must come out at 4 or more for the mid-bit strobe to be
  // distinct from the wrap point.
  function automatic int calc_bps_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_bps_half(input int clk_freq, input int baud);
    return calc_bps_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/rx_module_if.sv
// rx_module_if: user-facing signal bundle of the UART receiver.
//   RX_En_Sig    - receive enable (master -> receiver)
//   RX_Pin_In    - asynchronous serial line, idle high (master -> receiver)
//   RX_Data      - last correctly framed byte (receiver -> master)
//   RX_Done_Sig  - one-cycle pulse when RX_Data is loaded (receiver -> master)
//   RX_Err_Sig   - one-cycle pulse on a framing error (receiver -> master)
//   RX_State     - current receiver FSM state, for observation only
// Done and Err are pulses with no back-pressure: the consumer must capture
// RX_Data in the cycle RX_Done_Sig is high or on any later cycle before the
// next Done; there is no ready signal.
interface rx_module_if;
  import rs232_pkg::*;

  logic       RX_En_Sig;
  logic       RX_Pin_In;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       RX_Err_Sig;
  rx_state_t  RX_State;

  modport master (
    output RX_En_Sig, RX_Pin_In,
    input  RX_Data, RX_Done_Sig, RX_Err_Sig, RX_State
  );

  modport slave (
    input  RX_En_Sig, RX_Pin_In,
    output RX_Data, RX_Done_Sig, RX_Err_Sig, RX_State
  );
endinterface

// File: rtl/rx_bps_module.sv
// rx_bps_module: bit timer for the UART receiver.
//   CLK, RST_N  - clock, asynchronous active-low reset
//   Count_Sig   - 1: count, wrapping at BPS_DIV-1; 0: hold the count at zero
//   BPS_CLK     - one-cycle strobe when the count reaches BPS_HALF-1 (mid-bit)
module rx_bps_module
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic Count_Sig,
  output logic BPS_CLK
);

  localparam int BPS_DIV  = calc_bps_div(CLK_FREQ, BAUD);
  localparam int BPS_HALF = calc_bps_half(CLK_FREQ, BAUD);
  localparam int CNT_W    = $clog2(BPS_DIV);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (!Count_Sig) begin
      r_count <= '0;
    end else if (r_count == CNT_MAX) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_ONE;
    end
  end

  // Gated by Count_Sig so a stale zero count in IDLE never strobes.
  assign BPS_CLK = Count_Sig && (r_count == CNT_MID);

endmodule

// File: rtl/rx_control_module.sv
// rx_control_module: line conditioning and frame FSM of the UART receiver.
//   CLK, RST_N   - clock, asynchronous active-low reset
//   RX_En_Sig    - receive enable; low forces IDLE on the next cycle
//   RX_Pin_In    - asynchronous serial line
//   BPS_CLK      - mid-bit sample strobe from the bit timer
//   Count_Sig    - runs the bit timer from START through STOP
//   RX_Data      - last correctly framed byte
//   RX_Done_Sig  - registered pulse, cycle after a good stop sample
//   RX_Err_Sig   - registered pulse, cycle after a low stop sample
//   RX_State     - current FSM state
module rx_control_module
  import rs232_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RX_En_Sig,
  input  logic                 RX_Pin_In,
  input  logic                 BPS_CLK,
  output logic                 Count_Sig,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Done_Sig,
  output logic                 RX_Err_Sig,
  output rx_state_t            RX_State
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  // Two-flop synchronizer plus one history flop; all reset to the idle level
  // so leaving reset never looks like a start edge.
  logic r_sync1, r_sync2, r_prev;

  rx_state_t            r_state, w_state_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic [2:0]           r_idx,   w_idx_n;
  logic [DATA_BITS-1:0] r_data,  w_data_n;
  logic                 r_done,  w_done_n;
  logic                 r_err,   w_err_n;
  logic                 w_fall;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
      r_prev  <= IDLE_LEVEL;
    end else begin
      r_sync1 <= RX_Pin_In;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = (r_sync2 == 1'b0) && (r_prev == 1'b1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= RX_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_idx   <= w_idx_n;
      r_data  <= w_data_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_idx_n   = r_idx;
    w_data_n  = r_data;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;

    if (!RX_En_Sig) begin
      w_state_n = RX_IDLE;
    end else begin
      case (r_state)
        RX_IDLE: begin
          // The timer is already held at zero here, so the edge cycle is
          // the reference point for all later mid-bit samples.
          if (w_fall) w_state_n = RX_START;
        end
        RX_START: begin
          if (BPS_CLK) begin
            if (r_sync2 == 1'b0) begin
              w_state_n = RX_DATA;
              w_idx_n   = '0;
            end else begin
              w_state_n = RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (BPS_CLK) begin
            // Shift in at the MSB: after eight bits the first one is at bit 0.
            w_shift_n = {r_sync2, r_shift[DATA_BITS-1:1]};
            if (r_idx == LAST_IDX) begin
              w_state_n = RX_STOP;
            end else begin
              w_idx_n = r_idx + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (BPS_CLK) begin
            if (r_sync2 == STOP_LEVEL) begin
              w_data_n  = r_shift;
              w_done_n  = 1'b1;
              w_state_n = RX_IDLE;
            end else begin
              w_err_n   = 1'b1;
              w_state_n = RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          // Hold off until the line is released so a stuck-low line
          // produces a single error rather than a stream of frames.
          if (r_sync2 == IDLE_LEVEL) w_state_n = RX_IDLE;
        end
        default: w_state_n = RX_IDLE;
      endcase
    end
  end

  assign Count_Sig   = (r_state == RX_START) || (r_state == RX_DATA) ||
                       (r_state == RX_STOP);
  assign RX_Data     = r_data;
  assign RX_Done_Sig = r_done;
  assign RX_Err_Sig  = r_err;
  assign RX_State    = r_state;

endmodule

// File: rtl/rx_module.sv
// rx_module: RS232 8N1 UART receiver top.
//   CLK, RST_N  - clock, asynchronous active-low reset
//   rx_bus      - rx_module_if slave: RX_En_Sig, RX_Pin_In in;
//                 RX_Data, RX_Done_Sig, RX_Err_Sig, RX_State out
// Bit timing is CLK_FREQ / BAUD cycles per bit, matching the transmitter.
module rx_module
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        CLK,
  input  logic        RST_N,
  rx_module_if.slave  rx_bus
);

  logic w_bps_clk;
  logic w_count_sig;

  rx_bps_module #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_bps (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .Count_Sig (w_count_sig),
    .BPS_CLK   (w_bps_clk)
  );

  rx_control_module u_ctrl (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .RX_En_Sig   (rx_bus.RX_En_Sig),
    .RX_Pin_In   (rx_bus.RX_Pin_In),
    .BPS_CLK     (w_bps_clk),
    .Count_Sig   (w_count_sig),
    .RX_Data     (rx_bus.RX_Data),
    .RX_Done_Sig (rx_bus.RX_Done_Sig),
    .RX_Err_Sig  (rx_bus.RX_Err_Sig),
    .RX_State    (rx_bus.RX_State)
  );

endmodule
